vga_timing: RTL and testbench

//  Video timing generator + pixel output pipeline for the video display path.

---
 rtl/vga_timing.sv | 184 ++++++++++++++++++
 tb/tb_vga_timing.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: video timing generator and pixel output pipeline.
// Free-running line/frame counters issue pixel requests (PIX_REQ/PIX_X/PIX_Y)
// to the frame source. The sync, blank and RGB outputs are delayed so they
// line up with PIX_DATA returning FETCH_LAT cycles after each request.
// Optional feature: define VGA_PATTERN_EN to add an SW_PATTERN input that
// selects internal 8-bar colour bars instead of PIX_DATA.
module vga_timing #(
    parameter int   HDISP     = 800,
    parameter int   HFP       = 40,
    parameter int   HPULSE    = 128,
    parameter int   HBP       = 88,
    parameter int   VDISP     = 600,
    parameter int   VFP       = 1,
    parameter int   VPULSE    = 4,
    parameter int   VBP       = 23,
    parameter logic HS_POL    = 1'b1,
    parameter logic VS_POL    = 1'b1,
    parameter int   FETCH_LAT = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       PIX_REQ,
    output logic [$clog2(HDISP)-1:0]   PIX_X,
    output logic [$clog2(VDISP)-1:0]   PIX_Y,
    output logic                       FRAME_START,
    input  logic [23:0]                PIX_DATA,
`ifdef VGA_PATTERN_EN
    input  logic                       SW_PATTERN,
`endif
    output logic                       VGA_HS,
    output logic                       VGA_VS,
    output logic                       VGA_BLANK,
    output logic [7:0]                 VGA_R,
    output logic [7:0]                 VGA_G,
    output logic [7:0]                 VGA_B
);

    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);
    // One extra bit so region bounds equal to HTOTAL/VTOTAL do not wrap.
    localparam int HXW    = HW + 1;
    localparam int VXW    = VW + 1;

    localparam logic [HXW-1:0] H_DISP_END = HXW'(HDISP);
    localparam logic [HXW-1:0] H_SYNC_BEG = HXW'(HDISP + HFP);
    localparam logic [HXW-1:0] H_SYNC_END = HXW'(HDISP + HFP + HPULSE);
    localparam logic [HW-1:0]  H_LAST     = HW'(HTOTAL - 1);
    localparam logic [VXW-1:0] V_DISP_END = VXW'(VDISP);
    localparam logic [VXW-1:0] V_SYNC_BEG = VXW'(VDISP + VFP);
    localparam logic [VXW-1:0] V_SYNC_END = VXW'(VDISP + VFP + VPULSE);
    localparam logic [VW-1:0]  V_LAST     = VW'(VTOTAL - 1);

    logic [HW-1:0]        hcnt_q, hcnt_d;
    logic [VW-1:0]        vcnt_q, vcnt_d;
    logic [HXW-1:0]       hcnt_x;
    logic [VXW-1:0]       vcnt_x;
    logic                 disp_act, hs_act, vs_act;
    logic [FETCH_LAT-1:0] disp_dly_q, hs_dly_q, vs_dly_q;
    logic                 vga_hs_q, vga_vs_q, vga_blank_q;
    logic [23:0]          rgb_q, rgb_d;

`ifdef VGA_PATTERN_EN
    localparam int BAR_SH = $clog2(HDISP / 8);

    logic [XW-1:0] col_dly_q [FETCH_LAT];

    // Colour bar lookup: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [23:0] bar_colour(input logic [XW-1:0] col);
        logic [2:0] idx;
        idx = 3'(col >> BAR_SH);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction
`endif

    // Next-state for the line/frame counters: hcnt wraps each line, vcnt on the hcnt wrap.
    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage 0: zero-delay decode of the counters into region flags and the request.
    always_comb begin
        hcnt_x      = {1'b0, hcnt_q};
        vcnt_x      = {1'b0, vcnt_q};
        disp_act    = (hcnt_x < H_DISP_END) && (vcnt_x < V_DISP_END);
        hs_act      = (hcnt_x >= H_SYNC_BEG) && (hcnt_x < H_SYNC_END);
        vs_act      = (vcnt_x >= V_SYNC_BEG) && (vcnt_x < V_SYNC_END);
        PIX_REQ     = disp_act && !RST;
        PIX_X       = PIX_REQ ? hcnt_q[XW-1:0] : '0;
        PIX_Y       = PIX_REQ ? vcnt_q[YW-1:0] : '0;
        FRAME_START = !RST && (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Stages 1..FETCH_LAT: region flags wait for the frame source to return data.
    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_dly_q <= '0;
            hs_dly_q   <= '0;
            vs_dly_q   <= '0;
        end else begin
            disp_dly_q[0] <= disp_act;
            hs_dly_q[0]   <= hs_act;
            vs_dly_q[0]   <= vs_act;
            for (int i = 1; i < FETCH_LAT; i++) begin
                disp_dly_q[i] <= disp_dly_q[i-1];
                hs_dly_q[i]   <= hs_dly_q[i-1];
                vs_dly_q[i]   <= vs_dly_q[i-1];
            end
        end
    end

`ifdef VGA_PATTERN_EN
    // Column travels with the display flag so the bars share the PIX_DATA latency.
    always_ff @(posedge CLK) begin
        col_dly_q[0] <= hcnt_q[XW-1:0];
        for (int i = 1; i < FETCH_LAT; i++) begin
            col_dly_q[i] <= col_dly_q[i-1];
        end
    end
`endif

    // Pixel select: returned data (or bars) while displaying, black while blanked.
    always_comb begin
        rgb_d = '0;
        if (disp_dly_q[FETCH_LAT-1]) begin
`ifdef VGA_PATTERN_EN
            rgb_d = SW_PATTERN ? bar_colour(col_dly_q[FETCH_LAT-1]) : PIX_DATA;
`else
            rgb_d = PIX_DATA;
`endif
        end
    end

    // Output stage: registered DAC signals; reset clears colour too so no stale pixel leaks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            vga_hs_q    <= ~HS_POL;
            vga_vs_q    <= ~VS_POL;
            vga_blank_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            vga_hs_q    <= hs_dly_q[FETCH_LAT-1] ? HS_POL : ~HS_POL;
            vga_vs_q    <= vs_dly_q[FETCH_LAT-1] ? VS_POL : ~VS_POL;
            vga_blank_q <= disp_dly_q[FETCH_LAT-1];
            rgb_q       <= rgb_d;
        end
    end

    assign VGA_HS    = vga_hs_q;
    assign VGA_VS    = vga_vs_q;
    assign VGA_BLANK = vga_blank_q;
    assign VGA_R     = rgb_q[23:16];
    assign VGA_G     = rgb_q[15:8];
    assign VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed bench for vga_timing with small timing parameters
// (HTOTAL=15, VTOTAL=8, FETCH_LAT=2). A frame-source model answers each
// request with {A5, Y, X} two cycles later.
module tb_vga_timing;

    localparam int HDISP = 8, HFP = 2, HPULSE = 3, HBP = 2;
    localparam int VDISP = 4, VFP = 1, VPULSE = 2, VBP = 1;
    localparam int FETCH_LAT = 2;
    localparam int HTOT = 15;
    localparam int VTOT = 8;
    localparam int LAT  = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PIX_REQ;
    logic [2:0]  PIX_X;
    logic [1:0]  PIX_Y;
    logic        FRAME_START;
    logic [23:0] PIX_DATA = '0;
    logic        VGA_HS, VGA_VS, VGA_BLANK;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
`ifdef VGA_PATTERN_EN
    logic        SW_PATTERN = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [23:0] mem_d1 = '0;
    logic [23:0] cap    = '0;
    int pat_from = 1000000;

    int hs_first, hs_line0, blank_first, blank_run, vs_first, vs_cnt, blank_late, fs_cnt;
    bit blank_done;

    vga_timing #(
        .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
        .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(FETCH_LAT)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .PIX_REQ(PIX_REQ),
        .PIX_X(PIX_X),
        .PIX_Y(PIX_Y),
        .FRAME_START(FRAME_START),
        .PIX_DATA(PIX_DATA),
`ifdef VGA_PATTERN_EN
        .SW_PATTERN(SW_PATTERN),
`endif
        .VGA_HS(VGA_HS),
        .VGA_VS(VGA_VS),
        .VGA_BLANK(VGA_BLANK),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the frame source returns the request from two cycles back.
    task automatic tick();
        @(negedge CLK);
        cap = {8'hA5, 6'b0, PIX_Y, 5'b0, PIX_X};
        @(posedge CLK);
        #1;
        PIX_DATA = mem_d1;
        mem_d1   = cap;
    endtask

    function automatic logic [23:0] bar(input int col);
        case (col)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // k counts cycles since reset release; outputs reflect counter state k-LAT.
    task automatic check_cycle(input int k);
        int hk, vk, ho, vo;
        logic ereq, eb, ehs, evs;
        logic [23:0] ergb;
        hk   = k % HTOT;
        vk   = (k / HTOT) % VTOT;
        ereq = (hk < HDISP) && (vk < VDISP);
        chk($sformatf("pix_req@%0d", k), 32'(PIX_REQ), 32'(ereq));
        chk($sformatf("pix_x@%0d", k), 32'(PIX_X), ereq ? 32'(hk) : 32'd0);
        chk($sformatf("pix_y@%0d", k), 32'(PIX_Y), ereq ? 32'(vk) : 32'd0);
        chk($sformatf("frame_start@%0d", k), 32'(FRAME_START), 32'(k % (HTOT * VTOT) == 0));
        eb = 1'b0; ehs = 1'b0; evs = 1'b0; ergb = '0;
        if (k >= LAT) begin
            ho  = (k - LAT) % HTOT;
            vo  = ((k - LAT) / HTOT) % VTOT;
            eb  = (ho < HDISP) && (vo < VDISP);
            ehs = (ho >= 10) && (ho < 13);
            evs = (vo >= 5) && (vo < 7);
            if (eb) ergb = (k >= pat_from) ? bar(ho) : {8'hA5, 8'(vo), 8'(ho)};
        end
        chk($sformatf("blank@%0d", k), 32'(VGA_BLANK), 32'(eb));
        chk($sformatf("hs@%0d", k), 32'(VGA_HS), 32'(ehs));
        chk($sformatf("vs@%0d", k), 32'(VGA_VS), 32'(evs));
        chk($sformatf("rgb@%0d", k), 32'({VGA_R, VGA_G, VGA_B}), 32'(ergb));
    endtask

    task automatic clear_stats();
        hs_first = -1; hs_line0 = 0; blank_first = -1; blank_run = 0;
        blank_done = 1'b0; vs_first = -1; vs_cnt = 0; blank_late = 0; fs_cnt = 0;
    endtask

    task automatic run(input int k0, input int n);
        for (int k = k0; k < k0 + n; k++) begin
            check_cycle(k);
            if (VGA_HS && hs_first < 0) hs_first = k;
            if (VGA_HS && k >= 3 && k < 18) hs_line0++;
            if (VGA_BLANK && blank_first < 0) blank_first = k;
            if (blank_first >= 0 && !blank_done) begin
                if (VGA_BLANK) blank_run++;
                else blank_done = 1'b1;
            end
            if (VGA_VS && vs_first < 0) vs_first = k;
            if (VGA_VS && k >= 3 && k < 123) vs_cnt++;
            if (VGA_BLANK && k >= 63 && k < 123) blank_late++;
            if (FRAME_START) fs_cnt++;
            tick();
        end
    endtask

    task automatic check_stats(input string sfx);
        chk({"hs_first", sfx}, 32'(hs_first), 32'd13);
        chk({"hs_len_line0", sfx}, 32'(hs_line0), 32'd3);
        chk({"blank_first", sfx}, 32'(blank_first), 32'd3);
        chk({"blank_run", sfx}, 32'(blank_run), 32'd8);
        chk({"vs_first", sfx}, 32'(vs_first), 32'd78);
        chk({"vs_len", sfx}, 32'(vs_cnt), 32'd30);
        chk({"blank_lines4_7", sfx}, 32'(blank_late), 32'd0);
        chk({"frame_starts", sfx}, 32'(fs_cnt), 32'd2);
    endtask

    initial begin
        // Reset held for five cycles: everything inactive.
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_pix_req", 32'(PIX_REQ), 32'd0);
            chk("rst_frame_start", 32'(FRAME_START), 32'd0);
            chk("rst_blank", 32'(VGA_BLANK), 32'd0);
            chk("rst_hs", 32'(VGA_HS), 32'd0);
            chk("rst_vs", 32'(VGA_VS), 32'd0);
            chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        end
        RST = 1'b0;
        #1;

        // Two full frames of free running with per-cycle checks.
        clear_stats();
        run(0, 240);
        check_stats("_boot");

        // Move to hcnt=5, vcnt=2 of the third frame and pulse reset for one cycle.
        run(240, 35);
        check_cycle(275);
        RST = 1'b1;
        #1;
        chk("midrst_pix_req", 32'(PIX_REQ), 32'd0);
        chk("midrst_pix_x", 32'(PIX_X), 32'd0);
        chk("midrst_frame_start", 32'(FRAME_START), 32'd0);
        tick();
        RST = 1'b0;
        #1;
        clear_stats();
        run(0, 130);
        check_stats("_after_rst");

`ifdef VGA_PATTERN_EN
        // Colour bars: one pixel per bar with HDISP=8.
        SW_PATTERN = 1'b1;
        pat_from   = 131;
        run(130, 30);
        SW_PATTERN = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
